// File: rtl/ifu_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_fetch_pkg;

    // Fetch sequencer states.
    typedef enum logic [2:0] {
        ST_REQ   = 3'd0,
        ST_WAIT  = 3'd1,
        ST_OUT   = 3'd2,
        ST_EXEC  = 3'd3,
        ST_FAULT = 3'd4
    } fetch_state_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

    // Instructions are word aligned: the low two PC bits must equal this.
    localparam logic [1:0] INST_ALIGN_MASK = 2'b00;

endpackage

// File: rtl/ifu_fetch_pcreg.sv
// Architectural PC register, next-PC alignment check and fault PC capture.
module ifu_fetch_pcreg
    import ifu_fetch_pkg::*;
#(
    parameter int          XLEN     = 32,
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [XLEN-1:0] pc_next,
    input  logic            resp_fault,
    output logic [XLEN-1:0] pc,
    output logic            misaligned,
    output logic [XLEN-1:0] fault_pc
);

    logic [XLEN-1:0] pc_reg;
    logic [XLEN-1:0] fault_pc_reg;

    // The next PC is only meaningful while load is asserted; the check is purely combinational.
    always_comb begin
        misaligned = (pc_next[1:0] != INST_ALIGN_MASK);
    end

    // PC register: reset vector on reset, otherwise loaded only from the EXU.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_reg <= RESET_PC[XLEN-1:0];
        end else if (load) begin
            pc_reg <= pc_next;
        end
    end

    // Fault PC: the fetch address on a bus error, or the offending target on a misaligned load.
    always_ff @(posedge clk) begin
        if (!rst) begin
            fault_pc_reg <= '0;
        end else if (resp_fault) begin
            fault_pc_reg <= pc_reg;
        end else if (load && misaligned) begin
            fault_pc_reg <= pc_next;
        end
    end

    assign pc       = pc_reg;
    assign fault_pc = fault_pc_reg;

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, fetches one instruction at a time and
// hands it to the decoder; the EXU supplies every next PC.
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    input  logic            imem_resp_err,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    input  logic            exu_valid,
    input  logic [XLEN-1:0] pc_next,
    output logic [31:0]     retire_cnt,
    output logic            fault,
    output logic [XLEN-1:0] fault_pc
);

    fetch_state_t    state_reg;
    logic            req_valid_reg;
    logic            inst_valid_reg;
    logic            fault_reg;
    logic [XLEN-1:0] inst_reg;
    logic [XLEN-1:0] inst_pc_reg;
    logic [31:0]     retire_cnt_reg;

    logic            pc_load;
    logic            resp_fault;
    logic            misaligned;
    logic [XLEN-1:0] pc;

    // EXU completion is honoured only once the instruction has been handed over (or in the same handshake).
    always_comb begin
        pc_load    = exu_valid && (((state_reg == ST_OUT) && inst_ready) || (state_reg == ST_EXEC));
        resp_fault = (state_reg == ST_WAIT) && imem_resp_valid && imem_resp_err;
    end

    ifu_fetch_pcreg #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pcreg (
        .clk        (clk),
        .rst        (rst),
        .load       (pc_load),
        .pc_next    (pc_next),
        .resp_fault (resp_fault),
        .pc         (pc),
        .misaligned (misaligned),
        .fault_pc   (fault_pc)
    );

    // Fetch sequencer with registered valids; the request valid rises one cycle after reset release.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg      <= ST_REQ;
            req_valid_reg  <= 1'b0;
            inst_valid_reg <= 1'b0;
            fault_reg      <= 1'b0;
            inst_reg       <= '0;
            inst_pc_reg    <= '0;
            retire_cnt_reg <= '0;
        end else begin
            case (state_reg)
                ST_REQ: begin
                    if (req_valid_reg && imem_req_ready) begin
                        req_valid_reg <= 1'b0;
                        state_reg     <= ST_WAIT;
                    end else begin
                        req_valid_reg <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (imem_resp_valid) begin
                        if (imem_resp_err) begin
                            fault_reg <= 1'b1;
                            state_reg <= ST_FAULT;
                        end else begin
                            inst_reg       <= imem_resp_data;
                            inst_pc_reg    <= pc;
                            inst_valid_reg <= 1'b1;
                            state_reg      <= ST_OUT;
                        end
                    end
                end
                ST_OUT: begin
                    if (inst_ready) begin
                        inst_valid_reg <= 1'b0;
                        if (exu_valid) begin
                            retire_cnt_reg <= retire_cnt_reg + 32'd1;
                            if (misaligned) begin
                                fault_reg <= 1'b1;
                                state_reg <= ST_FAULT;
                            end else begin
                                req_valid_reg <= 1'b1;
                                state_reg     <= ST_REQ;
                            end
                        end else begin
                            state_reg <= ST_EXEC;
                        end
                    end
                end
                ST_EXEC: begin
                    if (exu_valid) begin
                        retire_cnt_reg <= retire_cnt_reg + 32'd1;
                        if (misaligned) begin
                            fault_reg <= 1'b1;
                            state_reg <= ST_FAULT;
                        end else begin
                            req_valid_reg <= 1'b1;
                            state_reg     <= ST_REQ;
                        end
                    end
                end
                ST_FAULT: begin
                    fault_reg <= 1'b1;
                end
                default: begin
                    req_valid_reg  <= 1'b0;
                    inst_valid_reg <= 1'b0;
                    fault_reg      <= 1'b1;
                    state_reg      <= ST_FAULT;
                end
            endcase
        end
    end

    assign imem_req_valid = req_valid_reg;
    assign imem_req_addr  = pc;
    assign inst_valid     = inst_valid_reg;
    assign inst           = inst_reg;
    assign inst_pc        = inst_pc_reg;
    assign retire_cnt     = retire_cnt_reg;
    assign fault          = fault_reg;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: inputs driven and outputs checked on the falling edge.
module tb_ifu_fetch;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        imem_resp_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        exu_valid;
    logic [31:0] pc_next;
    logic [31:0] retire_cnt;
    logic        fault;
    logic [31:0] fault_pc;

    int total = 0;
    int bad   = 0;
    int accept_cnt = 0;

    ifu_fetch #(
        .RESET_PC (32'h8000_0000),
        .XLEN     (32)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .imem_resp_err   (imem_resp_err),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst            (inst),
        .inst_pc         (inst_pc),
        .exu_valid       (exu_valid),
        .pc_next         (pc_next),
        .retire_cnt      (retire_cnt),
        .fault           (fault),
        .fault_pc        (fault_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count accepted fetch requests and log each handshake.
    always @(posedge clk) begin
        if (rst && imem_req_valid && imem_req_ready) begin
            accept_cnt++;
            $display("req  addr=%h", imem_req_addr);
        end
        if (rst && inst_valid && inst_ready) begin
            $display("inst pc=%h data=%h", inst_pc, inst);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // From REQ with the request valid: one accepted request, then a good response.
    task automatic fetch_to_out(input logic [31:0] data);
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_err   = 1'b0;
        imem_resp_data  = data;
        @(negedge clk);
        imem_resp_valid = 1'b0;
    endtask

    initial begin
        rst             = 1'b0;
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        imem_resp_err   = 1'b0;
        inst_ready      = 1'b0;
        exu_valid       = 1'b0;
        pc_next         = '0;

        // Reset for three edges.
        repeat (3) @(negedge clk);
        check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        check("rst_fault", {31'd0, fault}, 32'd0);
        check("rst_retire", retire_cnt, 32'd0);
        check("rst_inst", inst, 32'd0);
        check("rst_fault_pc", fault_pc, 32'd0);
        rst = 1'b1;

        // First cycle after release: request to the reset vector.
        @(negedge clk);
        check("rel_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("rel_addr", imem_req_addr, 32'h8000_0000);

        // Request backpressure for four cycles.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_req_valid", {31'd0, imem_req_valid}, 32'd1);
            check("bp_req_addr", imem_req_addr, 32'h8000_0000);
        end
        imem_req_ready = 1'b1;
        @(negedge clk);
        check("acc_req_valid", {31'd0, imem_req_valid}, 32'd0);
        check("acc_count", accept_cnt, 32'd1);
        imem_req_ready = 1'b0;

        // Stray EXU strobe while waiting for memory.
        exu_valid = 1'b1;
        pc_next   = 32'hDEAD_BEE0;
        @(negedge clk);
        check("stray_retire", retire_cnt, 32'd0);
        check("stray_addr", imem_req_addr, 32'h8000_0000);
        exu_valid       = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h0010_0093;
        @(negedge clk);
        imem_resp_valid = 1'b0;
        check("out_valid", {31'd0, inst_valid}, 32'd1);
        check("out_inst", inst, 32'h0010_0093);
        check("out_pc", inst_pc, 32'h8000_0000);

        // Decoder backpressure for five cycles.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("ibp_valid", {31'd0, inst_valid}, 32'd1);
            check("ibp_inst", inst, 32'h0010_0093);
            check("ibp_pc", inst_pc, 32'h8000_0000);
        end

        // Handover and retire in the same cycle.
        inst_ready = 1'b1;
        exu_valid  = 1'b1;
        pc_next    = 32'h8000_0004;
        @(negedge clk);
        inst_ready = 1'b0;
        exu_valid  = 1'b0;
        check("seq_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("seq_addr", imem_req_addr, 32'h8000_0004);
        check("seq_retire", retire_cnt, 32'd1);
        check("seq_inst_valid", {31'd0, inst_valid}, 32'd0);

        // Second instruction: jump from OUT.
        fetch_to_out(32'h0000_0013);
        check("j_inst_pc", inst_pc, 32'h8000_0004);
        inst_ready = 1'b1;
        exu_valid  = 1'b1;
        pc_next    = 32'h8000_0100;
        @(negedge clk);
        inst_ready = 1'b0;
        exu_valid  = 1'b0;
        check("jump_req_valid", {31'd0, imem_req_valid}, 32'd1);
        check("jump_addr", imem_req_addr, 32'h8000_0100);
        check("jump_retire", retire_cnt, 32'd2);

        // Third instruction: handed over first, EXU completes later.
        fetch_to_out(32'h0020_0113);
        check("x_inst", inst, 32'h0020_0113);
        inst_ready = 1'b1;
        @(negedge clk);
        inst_ready = 1'b0;
        check("exec_inst_valid", {31'd0, inst_valid}, 32'd0);
        check("exec_req_valid", {31'd0, imem_req_valid}, 32'd0);
        exu_valid = 1'b1;
        pc_next   = 32'h8000_0008;
        @(negedge clk);
        exu_valid = 1'b0;
        check("exec_addr", imem_req_addr, 32'h8000_0008);
        check("exec_retire", retire_cnt, 32'd3);

        // Bus error on the fourth fetch.
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready  = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_err   = 1'b1;
        @(negedge clk);
        imem_resp_valid = 1'b0;
        imem_resp_err   = 1'b0;
        check("err_fault", {31'd0, fault}, 32'd1);
        check("err_fault_pc", fault_pc, 32'h8000_0008);
        imem_req_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            exu_valid  = i[0];
            inst_ready = 1'b1;
            pc_next    = 32'h8000_0200;
            @(negedge clk);
            check("flt_req_valid", {31'd0, imem_req_valid}, 32'd0);
            check("flt_inst_valid", {31'd0, inst_valid}, 32'd0);
        end
        imem_req_ready = 1'b0;
        exu_valid      = 1'b0;
        inst_ready     = 1'b0;
        check("flt_accepts", accept_cnt, 32'd4);
        check("flt_retire", retire_cnt, 32'd3);
        check("flt_sticky", {31'd0, fault}, 32'd1);

        // Reset out of FAULT.
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("r2_fault", {31'd0, fault}, 32'd0);
        check("r2_retire", retire_cnt, 32'd0);
        @(negedge clk);
        check("r2_addr", imem_req_addr, 32'h8000_0000);

        // Reset in WAIT with a response in the same cycle, and a late one after.
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready  = 1'b0;
        rst             = 1'b0;
        imem_resp_valid = 1'b1;
        imem_resp_data  = 32'h1234_5678;
        @(negedge clk);
        rst = 1'b1;
        check("mr_inst_valid", {31'd0, inst_valid}, 32'd0);
        check("mr_req_valid", {31'd0, imem_req_valid}, 32'd0);
        @(negedge clk);
        imem_resp_valid = 1'b0;
        check("mr_restart_valid", {31'd0, imem_req_valid}, 32'd1);
        check("mr_restart_addr", imem_req_addr, 32'h8000_0000);
        check("mr_inst_ignored", inst, 32'd0);
        check("mr_no_out", {31'd0, inst_valid}, 32'd0);
        check("mr_retire", retire_cnt, 32'd0);

        // Misaligned next PC from EXEC.
        fetch_to_out(32'h0000_0013);
        inst_ready = 1'b1;
        @(negedge clk);
        inst_ready = 1'b0;
        exu_valid  = 1'b1;
        pc_next    = 32'h8000_0102;
        @(negedge clk);
        exu_valid = 1'b0;
        check("mis_fault", {31'd0, fault}, 32'd1);
        check("mis_fault_pc", fault_pc, 32'h8000_0102);
        check("mis_retire", retire_cnt, 32'd1);
        check("mis_req_valid", {31'd0, imem_req_valid}, 32'd0);

        // Retire counter wrap.
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        fetch_to_out(32'h0000_0013);
        inst_ready = 1'b1;
        @(negedge clk);
        inst_ready = 1'b0;
        force dut.retire_cnt_reg = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.retire_cnt_reg;
        check("wrap_pre", retire_cnt, 32'hFFFF_FFFF);
        exu_valid = 1'b1;
        pc_next   = 32'h8000_0004;
        @(negedge clk);
        exu_valid = 1'b0;
        check("wrap_retire", retire_cnt, 32'd0);
        check("wrap_addr", imem_req_addr, 32'h8000_0004);
        check("wrap_req_valid", {31'd0, imem_req_valid}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
